// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_WIDTH          = 16;
    localparam int DEF_DEPTH          = 64;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && ((req & (NUM_REQ'(1) << cand)) != '0)) begin
                found = 1'b1;
                gnt   = NUM_REQ'(1) << cand;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one valid/ready memory port.
// Optional WAIT timeout/abort enabled by defining MEM_RR_ARBITER_TIMEOUT_EN.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_done_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          req_err_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    input  logic                          mem_ready_i,
    output state_e                        dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a requester raises req_valid_i with a stable payload and holds it
    // until its one-cycle req_done_o; toward memory, mem_valid_o pulses for exactly
    // one cycle and the transaction completes on the first mem_ready_i seen in WAIT.

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_wr_rd_q, mem_wr_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic                timeout_hit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        mem_valid_d = 1'b0;
        mem_wr_rd_d = mem_wr_rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = '0;
        rdata_d     = '0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_gnt;
                    gidx_d      = pick_idx;
                    mem_valid_d = 1'b1;
                    mem_wr_rd_d = req_wr_rd_i[pick_idx];
                    mem_addr_d  = req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = req_wdata_i[pick_idx*WIDTH +: WIDTH];
                    state_d     = ISSUE;
                end
            end
            // mem_ready_i is deliberately not looked at here
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                    done_d  = grant_q;
                    rdata_d = mem_wr_rd_q ? '0 : mem_rdata_i;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                grant_d  = '0;
                rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_rd_q <= mem_wr_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_done_o  = done_q;
    assign req_rdata_o = rdata_q;
    assign req_err_o   = err_q;
    assign grant_o     = grant_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_wr_rd_o = mem_wr_rd_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a one-cycle-latency memory model.
module tb_mem_rr_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int AW      = 6;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_wr_rd_i;
    logic [NUM_REQ*AW-1:0]   req_addr_i;
    logic [NUM_REQ*WIDTH-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]      req_done_o;
    logic [WIDTH-1:0]        req_rdata_o;
    logic                    req_err_o;
    logic [NUM_REQ-1:0]      grant_o;
    logic                    mem_valid_o;
    logic                    mem_wr_rd_o;
    logic [AW-1:0]           mem_addr_o;
    logic [WIDTH-1:0]        mem_wdata_o;
    logic [WIDTH-1:0]        mem_rdata_i;
    logic                    mem_ready_i;
    state_e                  dbg_state_o;

    int n_cmp;
    int n_mis;
    logic [NUM_REQ-1:0] exp_q[$];
    logic [NUM_REQ-1:0] exp_done;

    logic [WIDTH-1:0] mem [64];
    logic             mem_en;

    mem_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(64), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_wr_rd_i(req_wr_rd_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_done_o(req_done_o), .req_rdata_o(req_rdata_o), .req_err_o(req_err_o),
        .grant_o(grant_o), .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset block
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // memory model: answers one cycle after mem_valid_o
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_ready_i <= 1'b0;
            mem_rdata_i <= '0;
        end else begin
            mem_ready_i <= 1'b0;
            if (mem_valid_o && mem_en) begin
                if (mem_wr_rd_o) mem[mem_addr_o] <= mem_wdata_o;
                else             mem_rdata_i <= mem[mem_addr_o];
                mem_ready_i <= 1'b1;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic wr, input logic [AW-1:0] addr,
                           input logic [WIDTH-1:0] wdata);
        req_wr_rd_i[k]             = wr;
        req_addr_i[k*AW +: AW]     = addr;
        req_wdata_i[k*WIDTH +: WIDTH] = wdata;
        req_valid_i[k]             = 1'b1;
    endtask

    task automatic drop_req(input int k);
        req_valid_i[k] = 1'b0;
    endtask

    // scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(grant_o), 0);
        check({tag, "_done"}, 32'(req_done_o), 0);
        check({tag, "_rdata"}, 32'(req_rdata_o), 0);
        check({tag, "_err"}, 32'(req_err_o), 0);
        check({tag, "_mvalid"}, 32'(mem_valid_o), 0);
        check({tag, "_mwr"}, 32'(mem_wr_rd_o), 0);
        check({tag, "_maddr"}, 32'(mem_addr_o), 0);
        check({tag, "_mwdata"}, 32'(mem_wdata_o), 0);
        check({tag, "_state"}, 32'(dbg_state_o), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        mem_en = 1'b1;
        rst_ni = 1'b0;
        req_valid_i = '0;
        req_wr_rd_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        for (int i = 0; i < 64; i++) mem[i] <= '0;
        mem[5] <= 16'h1234;

        repeat (3) tick();
        check_zero("reset");
        rst_ni = 1'b1;
        tick();
        check("idle_grant", 32'(grant_o), 0);

        // single read by req0 of address 5
        set_req(0, 1'b0, 6'd5, 16'h0);
        tick();
        check("t1_grant", 32'(grant_o), 'h1);
        check("t1_mvalid_issue", 32'(mem_valid_o), 1);
        check("t1_maddr", 32'(mem_addr_o), 5);
        check("t1_mwr", 32'(mem_wr_rd_o), 0);
        tick();
        check("t1_mvalid_wait", 32'(mem_valid_o), 0);
        check("t1_state_wait", 32'(dbg_state_o), 32'(WAIT));
        check("t1_done_early", 32'(req_done_o), 0);
        tick();
        check("t1_done", 32'(req_done_o), 'h1);
        check("t1_rdata", 32'(req_rdata_o), 'h1234);
        check("t1_err", 32'(req_err_o), 0);
        check("t1_mvalid_resp", 32'(mem_valid_o), 0);
        drop_req(0);
        tick();
        check("t1_done_clear", 32'(req_done_o), 0);
        check("t1_grant_clear", 32'(grant_o), 0);
        check("t1_rdata_clear", 32'(req_rdata_o), 0);

        // req2 writes 0xBEEF to 63 then reads it back
        set_req(2, 1'b1, 6'd63, 16'hBEEF);
        tick();
        check("t2w_grant", 32'(grant_o), 'h4);
        check("t2w_mwr", 32'(mem_wr_rd_o), 1);
        check("t2w_maddr", 32'(mem_addr_o), 63);
        check("t2w_mwdata", 32'(mem_wdata_o), 'hBEEF);
        tick();
        tick();
        check("t2w_done", 32'(req_done_o), 'h4);
        check("t2w_rdata", 32'(req_rdata_o), 0);
        check("t2w_err", 32'(req_err_o), 0);
        drop_req(2);
        tick();
        check("t2_hold_maddr", 32'(mem_addr_o), 63);
        check("t2_hold_mwr", 32'(mem_wr_rd_o), 1);
        check("t2_hold_mwdata", 32'(mem_wdata_o), 'hBEEF);
        set_req(2, 1'b0, 6'd63, 16'h0);
        tick();
        check("t2r_grant", 32'(grant_o), 'h4);
        check("t2r_mwr", 32'(mem_wr_rd_o), 0);
        tick();
        tick();
        check("t2r_done", 32'(req_done_o), 'h4);
        check("t2r_rdata", 32'(req_rdata_o), 'hBEEF);
        check("t2r_err", 32'(req_err_o), 0);
        drop_req(2);
        tick();

        // req1 alone moves rr_ptr to 2, then req0 and req3 compete
        set_req(1, 1'b0, 6'd63, 16'h0);
        tick();
        check("t4_pre_grant", 32'(grant_o), 'h2);
        tick();
        tick();
        check("t4_pre_done", 32'(req_done_o), 'h2);
        drop_req(1);
        tick();
        set_req(0, 1'b0, 6'd5, 16'h0);
        set_req(3, 1'b0, 6'd63, 16'h0);
        tick();
        check("t4_first_grant", 32'(grant_o), 'h8);
        tick();
        tick();
        check("t4_first_done", 32'(req_done_o), 'h8);
        check("t4_first_rdata", 32'(req_rdata_o), 'hBEEF);
        drop_req(3);
        tick();
        check("t4_gap_done", 32'(req_done_o), 0);
        tick();
        check("t4_second_grant", 32'(grant_o), 'h1);
        tick();
        tick();
        check("t4_second_done", 32'(req_done_o), 'h1);
        check("t4_second_rdata", 32'(req_rdata_o), 'h1234);
        drop_req(0);
        tick();

        // all four held from reset release: 0,1,2,3,0,1 with done every 4 cycles
        rst_ni = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, 6'd5, 16'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        for (int c = 1; c <= 23; c++) begin
            tick();
            exp_done = (c % 4 == 3) ? exp_q.pop_front() : 4'b0000;
            check("t3_done_seq", 32'(req_done_o), 32'(exp_done));
        end
        check("t3_queue_empty", exp_q.size(), 0);
        req_valid_i = '0;
        tick();

        // reset during WAIT of a req1 write drops it; rr_ptr returns to 0
        set_req(1, 1'b1, 6'd10, 16'h5A5A);
        tick();
        check("t5_grant", 32'(grant_o), 'h2);
        tick();
        check("t5_state_wait", 32'(dbg_state_o), 32'(WAIT));
        rst_ni = 1'b0;
        tick();
        check_zero("t5_rst");
        rst_ni = 1'b1;
        set_req(3, 1'b0, 6'd5, 16'h0);
        tick();
        check("t5_regrant", 32'(grant_o), 'h2);
        tick();
        tick();
        check("t5_done", 32'(req_done_o), 'h2);
        check("t5_rdata", 32'(req_rdata_o), 0);
        check("t5_err", 32'(req_err_o), 0);
        drop_req(1);
        tick();
        check("t5_gap_done", 32'(req_done_o), 0);
        tick();
        check("t5_next_grant", 32'(grant_o), 'h8);
        tick();
        tick();
        check("t5_next_done", 32'(req_done_o), 'h8);
        check("t5_next_rdata", 32'(req_rdata_o), 'h1234);
        drop_req(3);
        tick();

        // memory never answers
        mem_en = 1'b0;
        set_req(0, 1'b0, 6'd5, 16'h0);
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
        for (int c = 1; c <= 17; c++) begin
            tick();
            check("t6_no_done_yet", 32'(req_done_o), 0);
        end
        tick();
        check("t6_to_done", 32'(req_done_o), 'h1);
        check("t6_to_err", 32'(req_err_o), 1);
        check("t6_to_rdata", 32'(req_rdata_o), 0);
        drop_req(0);
        tick();
        check("t6_err_clear", 32'(req_err_o), 0);
`else
        for (int c = 1; c <= 100; c++) begin
            tick();
            check("t6_grant_held", 32'(grant_o), 'h1);
            check("t6_no_done", 32'(req_done_o), 0);
        end
        check("t6_err_tied", 32'(req_err_o), 0);
`endif
        rst_ni = 1'b0;
        drop_req(0);
        mem_en = 1'b1;
        tick();
        rst_ni = 1'b1;
        tick();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
